// File: rtl/mult_arbiter_pkg.sv
// Shared constants for the two-port multiplier arbiter: FSM encodings,
// default operand width and requester port indices.
package mult_arbiter_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/mult_arbiter_mult.sv
// Unsigned shift-add multiplier. rst_i doubles as the start strobe: operands
// are captured while it is high and busy_o stays high until y_bo is final.
module mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    output logic               busy_o,
    output logic [2*WIDTH-1:0] y_bo
);

    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               run_q;

    // Terminates as soon as the remaining multiplier bits are all zero,
    // so latency depends on the bit length of b.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= {{WIDTH{1'b0}}, a_bi};
            b_q   <= b_bi;
            acc_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (b_q == '0) begin
                run_q <= 1'b0;
            end else begin
                if (b_q[0]) begin
                    acc_q <= acc_q + a_q;
                end
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
            end
        end
    end

    assign busy_o = rst_i | run_q;
    assign y_bo   = acc_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that lets two requesters share one multi-cycle
// multiplier; returns each product with a one-cycle acknowledge.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_i,
    input  logic [WIDTH-1:0]   a0_bi,
    input  logic [WIDTH-1:0]   b0_bi,
    output logic               ack0_o,
    output logic [2*WIDTH-1:0] y0_bo,
    input  logic               req1_i,
    input  logic [WIDTH-1:0]   a1_bi,
    input  logic [WIDTH-1:0]   b1_bi,
    output logic               ack1_o,
    output logic [2*WIDTH-1:0] y1_bo,
    output logic               busy_o
);

    logic [1:0]         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] y0_q, y0_d;
    logic [2*WIDTH-1:0] y1_q, y1_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;

    logic               pick;
    logic               m_rst;
    logic               m_busy;
    logic [2*WIDTH-1:0] m_y;

    // Global reset also returns the multiplier to a known state.
    assign m_rst = rst_i | (state_q == ST_START);

    mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk_i  (clk_i),
        .rst_i  (m_rst),
        .a_bi   (opa_q),
        .b_bi   (opb_q),
        .busy_o (m_busy),
        .y_bo   (m_y)
    );

    // On a tie the port that did not win last time is served.
    assign pick = (req0_i && req1_i) ? ~last_q : (req1_i ? P1 : P0);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    opa_d   = (pick == P1) ? a1_bi : a0_bi;
                    opb_d   = (pick == P1) ? b1_bi : b0_bi;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Product and ack are registered on entry to DONE so both
                // are visible exactly during the DONE cycle.
                if (!m_busy) begin
                    state_d = ST_DONE;
                    if (gnt_q == P1) begin
                        y1_d   = m_y;
                        ack1_d = 1'b1;
                    end else begin
                        y0_d   = m_y;
                        ack0_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= P0;
            last_q  <= P1;
            opa_q   <= '0;
            opb_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign ack0_o = ack0_q;
    assign ack1_o = ack1_q;
    assign y0_bo  = y0_q;
    assign y1_bo  = y1_q;
    assign busy_o = rst_i | (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed scoreboard bench for mult_arbiter: expected products are queued
// when requests are issued and compared whenever an acknowledge appears.
module tb_mult_arbiter;

    localparam int W = 8;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           req0_i = 1'b0;
    logic [W-1:0]   a0_bi = '0;
    logic [W-1:0]   b0_bi = '0;
    logic           ack0_o;
    logic [2*W-1:0] y0_bo;
    logic           req1_i = 1'b0;
    logic [W-1:0]   a1_bi = '0;
    logic [W-1:0]   b1_bi = '0;
    logic           ack1_o;
    logic [2*W-1:0] y1_bo;
    logic           busy_o;

    mult_arbiter #(.WIDTH(W)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req0_i (req0_i),
        .a0_bi  (a0_bi),
        .b0_bi  (b0_bi),
        .ack0_o (ack0_o),
        .y0_bo  (y0_bo),
        .req1_i (req1_i),
        .a1_bi  (a1_bi),
        .b1_bi  (b1_bi),
        .ack1_o (ack1_o),
        .y1_bo  (y1_bo),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int             port;
        logic [2*W-1:0] y;
    } exp_t;

    exp_t sb[$];
    int   ack_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [2*W-1:0] exp_y0 = '0;
    logic [2*W-1:0] exp_y1 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input int a, input int b);
        exp_t e;
        e.port = p;
        e.y    = 16'(a * b);
        sb.push_back(e);
    endtask

    // Advance one cycle and score any acknowledge seen on the falling edge.
    task automatic tick();
        exp_t e;
        int   p;
        @(negedge clk_i);
        cyc++;
        if (!rst_i && (ack0_o || ack1_o)) begin
            check("ack_exclusive", 32'(ack0_o & ack1_o), 32'd0);
            p = ack1_o ? 1 : 0;
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(p), 32'd99);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(p), 32'(e.port));
                if (p == 0) exp_y0 = e.y;
                else        exp_y1 = e.y;
                check("y0", 32'(y0_bo), 32'(exp_y0));
                check("y1", 32'(y1_bo), 32'(exp_y1));
            end
        end
    endtask

    task automatic wait_ack(input int p);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if ((p == 0 && ack0_o) || (p == 1 && ack1_o)) got = 1'b1;
        end
        check($sformatf("ack%0d_seen", p), 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req0_i = 1'b0;
        req1_i = 1'b0;
        sb.delete();
        exp_y0 = '0;
        exp_y1 = '0;
        tick();
        check("rst_busy", 32'(busy_o), 32'd1);
        check("rst_ack0", 32'(ack0_o), 32'd0);
        check("rst_ack1", 32'(ack1_o), 32'd0);
        check("rst_y0", 32'(y0_bo), 32'd0);
        check("rst_y1", 32'(y1_bo), 32'd0);
        rst_i = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy_o), 32'd0);
    endtask

    int g1, g2, g3, n;

    initial begin
        tick();
        do_reset();

        // Single request, product and idle afterwards
        push(0, 3, 5);
        a0_bi = 8'd3; b0_bi = 8'd5; req0_i = 1'b1;
        wait_ack(0);
        req0_i = 1'b0;
        tick();
        check("busy_after_ack", 32'(busy_o), 32'd0);
        check("y0_hold", 32'(y0_bo), 32'd15);
        check("y1_untouched", 32'(y1_bo), 32'd0);

        // Maximum and zero operands
        push(1, 255, 255);
        a1_bi = 8'd255; b1_bi = 8'd255; req1_i = 1'b1;
        wait_ack(1);
        req1_i = 1'b0;
        push(0, 0, 200);
        a0_bi = 8'd0; b0_bi = 8'd200; req0_i = 1'b1;
        wait_ack(0);
        req0_i = 1'b0;
        tick();
        check("y1_max", 32'(y1_bo), 32'd65025);
        check("y0_zero", 32'(y0_bo), 32'd0);

        // Simultaneous first request after reset: port 0 wins the tie
        do_reset();
        push(0, 7, 9);
        push(1, 12, 12);
        a0_bi = 8'd7;  b0_bi = 8'd9;  req0_i = 1'b1;
        a1_bi = 8'd12; b1_bi = 8'd12; req1_i = 1'b1;
        wait_ack(0);
        req0_i = 1'b0;
        wait_ack(1);
        req1_i = 1'b0;
        tick();
        check("sim_y0", 32'(y0_bo), 32'd63);
        check("sim_y1", 32'(y1_bo), 32'd144);

        // Continuous contention: strict alternation with equal gaps
        push(0, 5, 6);
        push(1, 7, 6);
        push(0, 5, 6);
        push(1, 7, 6);
        a0_bi = 8'd5; b0_bi = 8'd6; req0_i = 1'b1;
        a1_bi = 8'd7; b1_bi = 8'd6; req1_i = 1'b1;
        wait_ack(0);
        wait_ack(1);
        wait_ack(0);
        wait_ack(1);
        req0_i = 1'b0;
        req1_i = 1'b0;
        n = ack_cyc.size();
        if (n >= 4) begin
            g1 = ack_cyc[n-3] - ack_cyc[n-4];
            g2 = ack_cyc[n-2] - ack_cyc[n-3];
            g3 = ack_cyc[n-1] - ack_cyc[n-2];
            check("gap2_eq", 32'(g2), 32'(g1));
            check("gap3_eq", 32'(g3), 32'(g1));
            check("gap_range", 32'((g1 >= 4) && (g1 <= W + 5)), 32'd1);
        end else begin
            check("contention_acks", 32'(n), 32'd4);
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Operand change after grant is ignored
        tick();
        push(0, 6, 4);
        a0_bi = 8'd6; b0_bi = 8'd4; req0_i = 1'b1;
        tick();
        tick();
        tick();
        a0_bi = 8'd9;
        wait_ack(0);
        req0_i = 1'b0;
        tick();
        check("latched_ops_y0", 32'(y0_bo), 32'd24);

        // Reset during WAIT aborts with no acknowledge
        a0_bi = 8'd10; b0_bi = 8'd10; req0_i = 1'b1;
        tick();
        tick();
        tick();
        check("busy_in_wait", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        req0_i = 1'b0;
        exp_y0 = '0;
        exp_y1 = '0;
        tick();
        check("abort_busy", 32'(busy_o), 32'd1);
        check("abort_ack0", 32'(ack0_o), 32'd0);
        check("abort_y0", 32'(y0_bo), 32'd0);
        check("abort_y1", 32'(y1_bo), 32'd0);
        rst_i = 1'b0;
        tick();
        check("abort_idle", 32'(busy_o), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_ack_y0", 32'(y0_bo), 32'd0);

        push(0, 2, 2);
        a0_bi = 8'd2; b0_bi = 8'd2; req0_i = 1'b1;
        wait_ack(0);
        req0_i = 1'b0;
        tick();
        check("after_abort_y0", 32'(y0_bo), 32'd4);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Two-port arbiter and sequencer for one shared multi-cycle shift-add multiplier (`mult`).
- Lets two requesters (e.g. the `cbrt` iteration and a squaring/power stage of the same function block) share a single multiplier instance.
- Grants round-robin, latches operands, issues the multiplier start pulse, waits for completion, then returns the product with a one-cycle acknowledge.
- Sits between the function-level FSMs and the `mult` instance and owns that instance.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req0_i  in  1  requester 0 request (level); held until ack0_o.
- a0_bi  in  WIDTH  requester 0 operand A; stable while req0_i is high.
- b0_bi  in  WIDTH  requester 0 operand B.
- ack0_o  out  1  one-cycle pulse: y0_bo is valid, request 0 done.
- y0_bo  out  2*WIDTH  requester 0 product; held until the next requester-0 completion.
- req1_i, a1_bi, b1_bi, ack1_o, y1_bo: same as port 0, for requester 1.
- busy_o  out  1  rst_i or state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, ack0_o=ack1_o=0, y0_bo=y1_bo=0, latched operands=0, last_grant=1 (so port 0 wins the first tie). The internal mult rst_i is driven by (rst_i | start), so the multiplier is also returned to idle.
- Multiplier contract:
  - Captures its operands in the cycle its rst_i is high.
  - Its busy_o is high from that cycle until the result is ready.
  - Its y_bo is valid once busy_o falls.
  - Latency is not fixed (≤ WIDTH+1 cycles); the arbiter must only watch busy_o.
- States:
  - IDLE:
    - If no request: stay.
    - If exactly one request: grant it.
    - If both: grant !last_grant.
    - On grant: latch that port's a/b into the op registers, set gnt, set last_grant=gnt, go START.
  - START: mult rst_i=1 with the latched operands; go WAIT.
  - WAIT: mult rst_i=0; stay while mult busy_o=1; when 0, go DONE.
  - DONE:
    - Copy mult y_bo into y{gnt}_bo.
    - ack{gnt}_o=1 for exactly this cycle.
    - Go IDLE.
- Latency, request-sample cycle to ack: 1 (IDLE) + 1 (START) + L (WAIT) + 1 → ack seen at edge L+3.
- Ack is never high on both ports in the same cycle. Ack is never high outside DONE.
- A req still high in the IDLE cycle after DONE is a new request. A requester must drop req in the ack cycle to avoid a repeat.
- Back-to-back: with both ports requesting continuously, grants strictly alternate 0,1,0,1.
- A req deasserted mid-operation does not abort: the operation completes, y is updated and ack pulses.
- A req rising during START/WAIT/DONE is not seen until the next IDLE.
- Operand changes after grant are ignored; the latched copies are used.
- rst_i asserted in any state aborts the operation (no ack) and applies the reset values on that edge.
- Arithmetic: unsigned, full 2*WIDTH-bit product, no truncation.
- y of the non-granted port is never modified.

Decomposition:
- Shared package:
  - State encodings IDLE/START/WAIT/DONE (2-bit).
  - WIDTH default.
  - Port index constants P0=0, P1=1.
- Sub-module: one instance of the existing `mult`, instantiated inside mult_arbiter; no other sub-modules.

Test Plan:
- Single request: req0 with a0=3, b0=5 → ack0 one pulse, y0_bo=15, y1_bo stays 0, ack1 never high, busy_o drops the cycle after ack.
- Max operands: req1 with a1=255, b1=255 → y1_bo=65025; zero operand a0=0, b0=200 → y0_bo=0.
- Simultaneous first request after reset: req0 (7*9) and req1 (12*12) → port 0 served first (y0=63), then port 1 (y1=144); acks in separate cycles.
- Continuous contention: both reqs held for 4 grants → grant order 0,1,0,1; each ack gap = L+3 cycles.
- Operand change after grant: a0 changed from 6 to 9 during WAIT with b0=4 → y0_bo=24.
- Reset mid-WAIT: assert rst_i → no ack, outputs 0, busy_o high only while rst_i is high. A new req0 (2*2) afterwards → y0_bo=4.
